// File: rtl/alu_ctrl_issue.sv
// ID/EX control register for the 5-stage MIPS pipeline: decodes opcode/funct into
// the EX-stage ALU code and downstream stage controls, and tracks illegal encodings.
module alu_ctrl_issue #(
   parameter int ILLEGAL_CNT_W  = 8,
   parameter bit NOP_ON_ILLEGAL = 1'b1
) (
   input  logic                     clock__i,
   input  logic                     reset__i,
   input  logic                     valid__i,
   input  logic [31:0]              instr__i,
   input  logic                     stall__i,
   input  logic                     flush__i,
   output logic                     valid__o,
   output logic [2:0]               ALUCtrl__o,
   output logic                     ALUSrc__o,
   output logic                     RegDst__o,
   output logic                     RegWrite__o,
   output logic                     MemRead__o,
   output logic                     MemWrite__o,
   output logic                     MemToReg__o,
   output logic                     Branch__o,
   output logic                     illegal__o,
   output logic [ILLEGAL_CNT_W-1:0] illegalCnt__o
);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [ILLEGAL_CNT_W-1:0] CNT_ONE = {{(ILLEGAL_CNT_W-1){1'b0}}, 1'b1};

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [2:0] dec_alu;
   logic       dec_alu_src;
   logic       dec_reg_dst;
   logic       dec_reg_write;
   logic       dec_mem_read;
   logic       dec_mem_write;
   logic       dec_mem_to_reg;
   logic       dec_branch;
   logic       dec_illegal;

   assign opcode = instr__i[31:26];
   assign funct  = instr__i[5:0];

   // Illegal encodings leave every field at the bubble values, so the register
   // stage only has to choose the valid bit for them.
   always_comb begin
      dec_alu        = ALU_ADD;
      dec_alu_src    = 1'b0;
      dec_reg_dst    = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_branch     = 1'b0;
      dec_illegal    = 1'b0;
      if (instr__i != 32'h0000_0000) begin
         case (opcode)
            6'b000000: begin
               dec_reg_dst   = 1'b1;
               dec_reg_write = 1'b1;
               case (funct)
                  6'b100000: dec_alu = ALU_ADD;
                  6'b100010: dec_alu = ALU_SUB;
                  6'b100100: dec_alu = ALU_AND;
                  6'b100101: dec_alu = ALU_OR;
                  6'b101010: dec_alu = ALU_SLT;
                  default: begin
                     dec_reg_dst   = 1'b0;
                     dec_reg_write = 1'b0;
                     dec_illegal   = 1'b1;
                  end
               endcase
            end
            6'b100011: begin
               dec_alu_src    = 1'b1;
               dec_mem_read   = 1'b1;
               dec_mem_to_reg = 1'b1;
               dec_reg_write  = 1'b1;
            end
            6'b101011: begin
               dec_alu_src   = 1'b1;
               dec_mem_write = 1'b1;
            end
            6'b000100: begin
               dec_alu    = ALU_SUB;
               dec_branch = 1'b1;
            end
            6'b001000: begin
               dec_alu_src   = 1'b1;
               dec_reg_write = 1'b1;
            end
            6'b001100: begin
               dec_alu       = ALU_AND;
               dec_alu_src   = 1'b1;
               dec_reg_write = 1'b1;
            end
            6'b001101: begin
               dec_alu       = ALU_OR;
               dec_alu_src   = 1'b1;
               dec_reg_write = 1'b1;
            end
            default: dec_illegal = 1'b1;
         endcase
      end
   end

   // Flush beats stall beats load; a stalled or flushed cycle never touches the
   // illegal tracking, so an instruction held under stall is counted once.
   always_ff @(posedge clock__i or posedge reset__i) begin
      if (reset__i) begin
         valid__o      <= 1'b0;
         ALUCtrl__o    <= 3'b000;
         ALUSrc__o     <= 1'b0;
         RegDst__o     <= 1'b0;
         RegWrite__o   <= 1'b0;
         MemRead__o    <= 1'b0;
         MemWrite__o   <= 1'b0;
         MemToReg__o   <= 1'b0;
         Branch__o     <= 1'b0;
         illegal__o    <= 1'b0;
         illegalCnt__o <= '0;
      end else if (flush__i || (!stall__i && !valid__i)) begin
         valid__o    <= 1'b0;
         ALUCtrl__o  <= ALU_ADD;
         ALUSrc__o   <= 1'b0;
         RegDst__o   <= 1'b0;
         RegWrite__o <= 1'b0;
         MemRead__o  <= 1'b0;
         MemWrite__o <= 1'b0;
         MemToReg__o <= 1'b0;
         Branch__o   <= 1'b0;
      end else if (!stall__i) begin
         valid__o    <= dec_illegal ? !NOP_ON_ILLEGAL : 1'b1;
         ALUCtrl__o  <= dec_alu;
         ALUSrc__o   <= dec_alu_src;
         RegDst__o   <= dec_reg_dst;
         RegWrite__o <= dec_reg_write;
         MemRead__o  <= dec_mem_read;
         MemWrite__o <= dec_mem_write;
         MemToReg__o <= dec_mem_to_reg;
         Branch__o   <= dec_branch;
         if (dec_illegal) begin
            illegal__o <= 1'b1;
            if (illegalCnt__o != {ILLEGAL_CNT_W{1'b1}}) begin
               illegalCnt__o <= illegalCnt__o + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Table-driven bench for alu_ctrl_issue: two instances (bubble-on-illegal with a
// 2-bit counter, and issue-on-illegal with an 8-bit counter) share one stimulus.
module tb_alu_ctrl_issue;

   // Expected output bundle: {valid, ALUCtrl[2:0], ALUSrc, RegDst, RegWrite,
   // MemRead, MemWrite, MemToReg, Branch}
   localparam logic [10:0] E_ZERO = 11'b0_000_0_0_0_0_0_0_0;
   localparam logic [10:0] E_BUB  = 11'b0_010_0_0_0_0_0_0_0;
   localparam logic [10:0] E_NOP  = 11'b1_010_0_0_0_0_0_0_0;
   localparam logic [10:0] E_ADD  = 11'b1_010_0_1_1_0_0_0_0;
   localparam logic [10:0] E_SUB  = 11'b1_110_0_1_1_0_0_0_0;
   localparam logic [10:0] E_AND  = 11'b1_000_0_1_1_0_0_0_0;
   localparam logic [10:0] E_SLT  = 11'b1_111_0_1_1_0_0_0_0;
   localparam logic [10:0] E_LW   = 11'b1_010_1_0_1_1_0_1_0;
   localparam logic [10:0] E_SW   = 11'b1_010_1_0_0_0_1_0_0;
   localparam logic [10:0] E_BEQ  = 11'b1_110_0_0_0_0_0_0_1;
   localparam logic [10:0] E_ORI  = 11'b1_001_1_0_1_0_0_0_0;
   localparam logic [10:0] E_ADDI = 11'b1_010_1_0_1_0_0_0_0;
   localparam logic [10:0] E_ANDI = 11'b1_000_1_0_1_0_0_0_0;

   localparam logic [31:0] I_ADD  = 32'h0022_1820;
   localparam logic [31:0] I_SUB  = 32'h0022_1822;
   localparam logic [31:0] I_AND  = 32'h0022_1824;
   localparam logic [31:0] I_SLT  = 32'h0022_182A;
   localparam logic [31:0] I_LW   = 32'h8C22_0004;
   localparam logic [31:0] I_SW   = 32'hAC22_0004;
   localparam logic [31:0] I_BEQ  = 32'h1022_0003;
   localparam logic [31:0] I_ORI  = 32'h3422_0005;
   localparam logic [31:0] I_ADDI = 32'h2022_0005;
   localparam logic [31:0] I_ANDI = 32'h3022_0005;
   localparam logic [31:0] I_BADF = 32'h0022_1807;
   localparam logic [31:0] I_BADO = 32'hFC00_0000;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic        st;
      logic        fl;
      logic [10:0] exp;
      logic        vb;
      logic [1:0]  cnt_a;
      logic [7:0]  cnt_b;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [10:0] exp;
      logic        vb;
      logic [1:0]  cnt_a;
      logic [7:0]  cnt_b;
      logic        ill;
      int          tag;
   } sb_t;

   logic clock;
   logic reset;
   logic valid_in;
   logic [31:0] instr;
   logic stall;
   logic flush;

   logic       valid_a, src_a, dst_a, rw_a, mr_a, mw_a, m2r_a, br_a, ill_a;
   logic [2:0] alu_a;
   logic [1:0] cnt_a;
   logic       valid_b, src_b, dst_b, rw_b, mr_b, mw_b, m2r_b, br_b, ill_b;
   logic [2:0] alu_b;
   logic [7:0] cnt_b;

   int checks;
   int errors;
   sb_t sb[$];
   vec_t vecs[29];

   alu_ctrl_issue #(.ILLEGAL_CNT_W(2), .NOP_ON_ILLEGAL(1'b1)) dutA (
      .clock__i(clock), .reset__i(reset), .valid__i(valid_in), .instr__i(instr),
      .stall__i(stall), .flush__i(flush), .valid__o(valid_a), .ALUCtrl__o(alu_a),
      .ALUSrc__o(src_a), .RegDst__o(dst_a), .RegWrite__o(rw_a), .MemRead__o(mr_a),
      .MemWrite__o(mw_a), .MemToReg__o(m2r_a), .Branch__o(br_a),
      .illegal__o(ill_a), .illegalCnt__o(cnt_a)
   );

   alu_ctrl_issue #(.ILLEGAL_CNT_W(8), .NOP_ON_ILLEGAL(1'b0)) dutB (
      .clock__i(clock), .reset__i(reset), .valid__i(valid_in), .instr__i(instr),
      .stall__i(stall), .flush__i(flush), .valid__o(valid_b), .ALUCtrl__o(alu_b),
      .ALUSrc__o(src_b), .RegDst__o(dst_b), .RegWrite__o(rw_b), .MemRead__o(mr_b),
      .MemWrite__o(mw_b), .MemToReg__o(m2r_b), .Branch__o(br_b),
      .illegal__o(ill_b), .illegalCnt__o(cnt_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic v, input logic [31:0] i, input logic st,
                               input logic fl, input logic [10:0] e, input logic vb,
                               input logic [1:0] ca, input logic [7:0] cb, input logic il);
      vec_t r;
      r.v = v; r.instr = i; r.st = st; r.fl = fl; r.exp = e; r.vb = vb;
      r.cnt_a = ca; r.cnt_b = cb; r.ill = il;
      return r;
   endfunction

   task automatic cmp(input string name, input int tag, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s step %0d: got %h, expected %h", name, tag, act, req);
      end
   endtask

   task automatic pushExp(input logic [10:0] e, input logic vb, input logic [1:0] ca,
                          input logic [7:0] cb, input logic il, input int tag);
      sb_t s;
      s.exp = e; s.vb = vb; s.cnt_a = ca; s.cnt_b = cb; s.ill = il; s.tag = tag;
      sb.push_back(s);
   endtask

   // Drives one vector just after a clock edge and queues what EX must show after the next edge.
   task automatic applyStimulus(input vec_t r, input int tag);
      valid_in = r.v;
      instr    = r.instr;
      stall    = r.st;
      flush    = r.fl;
      pushExp(r.exp, r.vb, r.cnt_a, r.cnt_b, r.ill, tag);
   endtask

   task automatic checkOutput();
      sb_t s;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: output sampled with no expectation queued");
         return;
      end
      s = sb.pop_front();
      cmp("ctrlA", s.tag, {21'd0, valid_a, alu_a, src_a, dst_a, rw_a, mr_a, mw_a, m2r_a, br_a},
          {21'd0, s.exp});
      cmp("cntA", s.tag, {30'd0, cnt_a}, {30'd0, s.cnt_a});
      cmp("illA", s.tag, {31'd0, ill_a}, {31'd0, s.ill});
      cmp("ctrlB", s.tag, {21'd0, valid_b, alu_b, src_b, dst_b, rw_b, mr_b, mw_b, m2r_b, br_b},
          {21'd0, s.vb, s.exp[9:0]});
      cmp("cntB", s.tag, {24'd0, cnt_b}, {24'd0, s.cnt_b});
      cmp("illB", s.tag, {31'd0, ill_b}, {31'd0, s.ill});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = mk(1, I_ADD,  0, 0, E_ADD,  1, 0, 0, 0);
      vecs[1]  = mk(1, I_LW,   0, 0, E_LW,   1, 0, 0, 0);
      vecs[2]  = mk(1, I_SW,   0, 0, E_SW,   1, 0, 0, 0);
      vecs[3]  = mk(1, I_BEQ,  0, 0, E_BEQ,  1, 0, 0, 0);
      vecs[4]  = mk(1, I_ORI,  0, 0, E_ORI,  1, 0, 0, 0);
      vecs[5]  = mk(1, I_ADDI, 0, 0, E_ADDI, 1, 0, 0, 0);
      vecs[6]  = mk(1, I_ANDI, 0, 0, E_ANDI, 1, 0, 0, 0);
      vecs[7]  = mk(1, I_SUB,  0, 0, E_SUB,  1, 0, 0, 0);
      vecs[8]  = mk(1, I_AND,  1, 0, E_SUB,  1, 0, 0, 0);
      vecs[9]  = mk(1, I_AND,  1, 0, E_SUB,  1, 0, 0, 0);
      vecs[10] = mk(1, I_AND,  1, 0, E_SUB,  1, 0, 0, 0);
      vecs[11] = mk(1, I_AND,  0, 0, E_AND,  1, 0, 0, 0);
      vecs[12] = mk(1, I_SLT,  0, 0, E_SLT,  1, 0, 0, 0);
      vecs[13] = mk(1, I_SLT,  1, 1, E_BUB,  0, 0, 0, 0);
      vecs[14] = mk(0, I_ADD,  0, 0, E_BUB,  0, 0, 0, 0);
      vecs[15] = mk(1, I_BADF, 0, 0, E_BUB,  1, 1, 1, 1);
      vecs[16] = mk(1, I_BADO, 0, 0, E_BUB,  1, 2, 2, 1);
      vecs[17] = mk(1, I_ADD,  0, 0, E_ADD,  1, 2, 2, 1);
      vecs[18] = mk(1, I_BADO, 0, 0, E_BUB,  1, 3, 3, 1);
      vecs[19] = mk(1, I_BADO, 1, 0, E_BUB,  1, 3, 3, 1);
      vecs[20] = mk(1, I_BADO, 1, 0, E_BUB,  1, 3, 3, 1);
      vecs[21] = mk(1, I_ADD,  0, 0, E_ADD,  1, 3, 3, 1);
      vecs[22] = mk(1, I_BADF, 0, 0, E_BUB,  1, 3, 4, 1);
      vecs[23] = mk(1, I_BADO, 0, 0, E_BUB,  1, 3, 5, 1);
      vecs[24] = mk(1, I_BADF, 0, 1, E_BUB,  0, 3, 5, 1);
      vecs[25] = mk(1, 32'h0,  0, 0, E_NOP,  1, 3, 5, 1);
      vecs[26] = mk(0, I_BADO, 0, 0, E_BUB,  0, 3, 5, 1);
      vecs[27] = mk(1, I_ADD,  1, 0, E_BUB,  0, 3, 5, 1);
      vecs[28] = mk(1, I_ADD,  0, 0, E_ADD,  1, 3, 5, 1);

      // Reset held over live input: everything must stay zero.
      reset    = 1'b1;
      valid_in = 1'b1;
      instr    = I_ADD;
      stall    = 1'b0;
      flush    = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      pushExp(E_ZERO, 1'b0, 2'd0, 8'd0, 1'b0, -1);
      checkOutput();
      reset = 1'b0;

      for (int i = 0; i < 29; i++) begin
         applyStimulus(vecs[i], i);
         @(posedge clock);
         #1;
         checkOutput();
      end

      // Mid-stream reset clears outputs without waiting for a clock edge.
      reset = 1'b1;
      #1;
      pushExp(E_ZERO, 1'b0, 2'd0, 8'd0, 1'b0, 100);
      checkOutput();
      @(posedge clock);
      #1;
      pushExp(E_ZERO, 1'b0, 2'd0, 8'd0, 1'b0, 101);
      checkOutput();
      reset = 1'b0;
      applyStimulus(mk(1, I_LW, 0, 0, E_LW, 1, 0, 0, 0), 102);
      @(posedge clock);
      #1;
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- ID/EX-side producer of the ALU operation code and EX/MEM/WB control bits for the 5-stage MIPS pipeline.
- Decodes the instruction's opcode/funct in ID and registers the result into the ID/EX control register, honouring pipeline stall and flush.
- Outputs drive the 3-bit ALU control input of the EX-stage ALU plus downstream stage controls.
- Also tracks illegal encodings: a sticky flag and a saturating counter.

Parameters:
- ILLEGAL_CNT_W, 8, width of the saturating illegal-instruction counter.
- NOP_ON_ILLEGAL, 1, 1 = an illegal instruction issues as a bubble; 0 = it issues with ALUCtrl 010 and all write enables cleared.

Ports:
- clock__i  in  1  pipeline clock, rising edge.
- reset__i  in  1  asynchronous, active-high reset.
- valid__i  in  1  ID stage holds a valid instruction.
- instr__i  in  32  ID instruction; opcode = [31:26], funct = [5:0].
- stall__i  in  1  hazard unit: hold the ID/EX register.
- flush__i  in  1  branch/hazard: load a bubble.
- valid__o  out  1  EX stage holds a valid instruction.
- ALUCtrl__o  out  3  ALU operation code: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT.
- ALUSrc__o  out  1  1 = immediate operand B.
- RegDst__o  out  1  1 = rd, 0 = rt.
- RegWrite__o  out  1  register file write enable.
- MemRead__o  out  1  load.
- MemWrite__o  out  1  store.
- MemToReg__o  out  1  writeback selects memory data.
- Branch__o  out  1  BEQ, qualified by the ALU Zero flag downstream.
- illegal__o  out  1  sticky illegal-encoding flag.
- illegalCnt__o  out  ILLEGAL_CNT_W  saturating count of illegal encodings.

Behaviour:
- Reset (async, high): all outputs 0 immediately, including ALUCtrl__o = 000, the counter and the sticky flag. Outputs are all registers; there is no combinational path from inputs to outputs.
- Decode (combinational, internal):
  - R-type (op 000000): funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111. RegDst = 1, RegWrite = 1. Any other funct is illegal.
  - LW (100011): ALUCtrl 010; ALUSrc, MemRead, MemToReg, RegWrite = 1.
  - SW (101011): ALUCtrl 010; ALUSrc, MemWrite = 1.
  - BEQ (000100): ALUCtrl 110; Branch = 1.
  - ADDI (001000) -> 010; ANDI (001100) -> 000; ORI (001101) -> 001. Each sets ALUSrc = 1, RegWrite = 1.
  - Any other opcode is illegal.
  - Instruction word 0x00000000 (sll nop) is a legal bubble: it issues with valid = 1, all enables 0, ALUCtrl 010, and is not counted as illegal.
- Per rising edge, priority is flush > stall > load:
  - flush__i = 1: load a bubble (valid 0, all enables 0, ALUCtrl 010), regardless of stall__i.
  - stall__i = 1: hold every output register unchanged.
  - Otherwise, valid__i = 1: load the decoded values and set valid__o = 1.
  - Otherwise, valid__i = 0: load a bubble.
- Illegal handling, only when loading (no flush, no stall) with valid__i = 1 and an illegal decode:
  - Set illegal__o (cleared only by reset).
  - Increment illegalCnt__o, saturating at all-ones.
  - NOP_ON_ILLEGAL = 1: valid__o = 0. NOP_ON_ILLEGAL = 0: valid__o = 1 with all enables 0.
- No counting or flag update on stalled or flushed cycles, so an illegal instruction held across a stall is counted exactly once.
- Latency: 1 cycle from ID to EX.
- Bubble invariant: whenever valid__o = 0, RegWrite, MemRead, MemWrite and Branch are all 0.
- Reset asserted mid-stream clears all outputs immediately. The first load happens on the first rising edge after deassertion.

Test Plan:
- Reset with valid__i = 1 and instr ADD (0x00221820) -> all outputs 0 during reset. The first edge after release gives ALUCtrl 010, RegDst 1, RegWrite 1, valid 1.
- Issue LW 0x8C220004, SW 0xAC220004, BEQ 0x10220003, ORI 0x34220005 on back-to-back cycles -> one cycle later each: (010, ALUSrc/MemRead/MemToReg/RegWrite), (010, ALUSrc/MemWrite), (110, Branch), (001, ALUSrc/RegWrite).
- Issue SUB, assert stall for 3 cycles while instr__i changes to AND -> ALUCtrl stays 110 for 3 cycles, then becomes 000.
- Assert stall and flush together on a cycle where EX holds SLT (111) -> next cycle valid 0, all enables 0, ALUCtrl 010.
- With NOP_ON_ILLEGAL = 1, issue funct 000111, then op 111111 -> valid 0 both times, illegal__o = 1, count = 2. An illegal instruction held under a 2-cycle stall still counts once. With ILLEGAL_CNT_W = 2, 5 illegal issues -> count saturates at 3.
- Issue 0x00000000 -> valid 1, all enables 0, illegal__o unchanged.
